mod3_operand_sequencer: RTL and testbench
=========================================

// Module: mod3_operand_sequencer
// PURPOSE
//   Upstream feeder for the iterative 64-bit mod-3 core (source_64bit_mod3).
//   - Buffers 64-bit operands, each with a tag, arriving on a valid/ready stream.
//   - Drives the core's x/e pins one job at a time and waits for f.
//   - Returns remainder + tag on a valid/ready result stream, in arrival order.
//   - A watchdog turns a hung core into a flagged result.
// PARAMETERS
//   FIFO_DEPTH   4    operand buffer entries (power of 2, >=2)
//   TAG_W        4    width of the user tag carried with each operand
//   GAP_CYCLES   2    min cycles core_e held low between jobs and after reset
//   TIMEOUT      127  RUN cycles without core_f before the job is aborted
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   in_valid   in   1        operand offered
//   in_ready   out  1        operand accepted when in_valid & in_ready
//   in_data    in   64       operand
//   in_tag     in   TAG_W    tag returned with this operand's result
//   core_x     out  64       operand to core; stable while core_e=1
//   core_e     out  1        core enable; rising edge starts a job
//   core_s     in   2        core remainder
//   core_f     in   1        core finished
//   core_i     in   7        core step count, captured for debug
//   out_valid  out  1        result available
//   out_ready  in   1        result consumed when out_valid & out_ready
//   out_rem    out  2        x mod 3 (0..2); 0 when out_timeout=1
//   out_tag    out  TAG_W    tag of the job
//   out_steps  out  7        core_i at capture
//   out_timeout out 1        job aborted by watchdog
//   busy       out  1        FIFO non-empty or state != GAP
// BEHAVIOUR
//   Reset: all outputs 0 (in_ready 0); FIFO emptied; state GAP, gap count 0.
//   - Takes effect immediately mid-job: core_e drops asynchronously and any
//     pending result is discarded.
//   All outputs are registered; no combinational in->out paths.
//   FIFO:
//   - in_ready = !full, registered. It is 1 on the first clk after reset.
//   - A pop in the same cycle does NOT raise in_ready while full.
//   - Push and pop in the same cycle with count>0: count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   FSM:
//   - GAP: core_e=0. Counts to GAP_CYCLES, then moves to IDLE.
//   - IDLE: core_e=0. If FIFO non-empty:
//     - load core_x and the tag from the head, pop;
//     - core_e<=1, cycle counter<=0, go to RUN.
//     - IDLE->RUN takes 1 cycle.
//   - RUN: core_e=1, core_x held. Counter increments each cycle.
//     - core_f is ignored in the first RUN cycle.
//     - On core_f=1: capture core_s, core_i; out_timeout<=0; core_e<=0;
//       go to HOLD.
//     - If the counter reaches TIMEOUT first: out_rem<=0, out_timeout<=1;
//       core_e<=0; go to HOLD.
//   - HOLD: out_valid=1; out_rem/out_tag/out_steps/out_timeout held stable.
//     - On out_ready: out_valid<=0, go to GAP.
//   Latency: a push into an empty FIFO with the FSM in IDLE drives core_e high
//   2 cycles later. out_valid is asserted 1 cycle after core_f is sampled.
//   Capacity with out_ready=0: FIFO_DEPTH operands plus 1 held result.
// STRUCTURE
//   mod3_pkg:
//   - OPERAND_W=64, REM_W=2, STEP_W=7;
//   - state encoding {GAP, IDLE, RUN, HOLD};
//   - function ref_mod3(x) for benches.
//   Sub-module mod3_sync_fifo (data+tag, DEPTH param, full/empty/count).
//   The sequencer top holds the FSM, gap/watchdog counters and result register.
// TESTING (bench uses real source_64bit_mod3 unless noted; check vs ref_mod3)
//   1. Push 117, tag 0, out_ready=1 -> out_rem=0, tag 0, out_timeout=0.
//      core_x stable for the whole time core_e=1.
//   2. Back-to-back 425117/827425117/4294967295/0xFFFF_FFFF_FFFF_FFFF,
//      tags 1..4 -> rem 2,1,0,0 in order.
//      core_e is low >=GAP_CYCLES cycles between jobs.
//   3. out_ready=0, offer 8 ops -> exactly 5 accepted, then in_ready=0.
//      Raise out_ready -> all 5 drain in order, in_ready returns to 1.
//   4. Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid and
//      all result fields unchanged; no new core_e rise.
//   5. Stub core with f stuck 0 -> out_valid after TIMEOUT RUN cycles with
//      out_timeout=1, out_rem=0. Next op runs normally.
//   6. Assert rst_n low mid-RUN -> core_e, out_valid, in_ready go 0 at once;
//      FIFO empty after release. Push 117 -> rem 0.

Source files
------------

// File: rtl/mod3_pkg.sv
// -----------------------------------------------------------------------------
// mod3_pkg
// Shared definitions for the mod-3 operand sequencer.
//   OPERAND_W / REM_W / STEP_W : widths of the operand, remainder and step count
//   seq_state_e                : sequencer FSM states
//   ref_mod3()                 : plain arithmetic x mod 3, kept for benches
// -----------------------------------------------------------------------------
package mod3_pkg;

    localparam int OPERAND_W = 64;
    localparam int REM_W     = 2;
    localparam int STEP_W    = 7;

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } seq_state_e;

    function automatic logic [REM_W-1:0] ref_mod3(input logic [OPERAND_W-1:0] x);
        return REM_W'(x % 64'd3);
    endfunction

endpackage

// File: rtl/mod3_sync_fifo.sv
// -----------------------------------------------------------------------------
// mod3_sync_fifo
// Single-clock FIFO holding {tag, operand} entries.
//   push/wdata   : write request; only honoured while wr_ready=1
//   pop/rdata    : rdata shows the head entry; pop is ignored when empty
//   empty        : no entries stored (from the registered count)
//   wr_ready     : registered !full; a pop does not raise it in the same cycle
//   count_next   : occupancy after this cycle's push/pop, for registered status
// -----------------------------------------------------------------------------
module mod3_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       wr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ready_q, wr_ready_d;
    logic             push_s, pop_s;

    // Pointer and occupancy update; pointers wrap because DEPTH is a power of 2.
    always_comb begin
        push_s   = push & wr_ready_q;
        pop_s    = pop & (count_q != CNT_W'(0));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wr_ready_d = (count_d != CNT_W'(DEPTH));
    end

    // Pointer, count and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // Entry storage, cleared on reset so no stale operand is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata      = mem_q[rd_ptr_q];
    assign empty      = (count_q == CNT_W'(0));
    assign wr_ready   = wr_ready_q;
    assign count_next = count_d;

endmodule

// File: rtl/mod3_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mod3_operand_sequencer
// Feeds buffered operands one at a time to an iterative mod-3 core and returns
// remainder + tag in arrival order. A watchdog turns a hung core into a result
// flagged with out_timeout.
//   in_valid/in_ready/in_data/in_tag : operand stream (valid/ready)
//   core_x/core_e                    : operand and enable to the core
//   core_s/core_f/core_i             : remainder, finished, step count from core
//   out_valid/out_ready/out_rem/out_tag/out_steps/out_timeout : result stream
//   busy                             : FIFO non-empty or FSM not in GAP
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mod3_operand_sequencer
    import mod3_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 127
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [OPERAND_W-1:0] core_x,
    output logic                 core_e,
    input  logic [REM_W-1:0]     core_s,
    input  logic                 core_f,
    input  logic [STEP_W-1:0]    core_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REM_W-1:0]     out_rem,
    output logic [TAG_W-1:0]     out_tag,
    output logic [STEP_W-1:0]    out_steps,
    output logic                 out_timeout,
    output logic                 busy
);

    localparam int ENTRY_W = TAG_W + OPERAND_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam int GAP_W   = $clog2(GAP_CYCLES+1);
    localparam int RUN_W   = $clog2(TIMEOUT+1);

    seq_state_e           state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
    logic [OPERAND_W-1:0] core_x_q, core_x_d;
    logic                 core_e_q, core_e_d;
    logic                 out_valid_q, out_valid_d;
    logic [REM_W-1:0]     out_rem_q, out_rem_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic [STEP_W-1:0]    out_steps_q, out_steps_d;
    logic                 out_timeout_q, out_timeout_d;
    logic                 busy_q, busy_d;

    logic                 fifo_pop_s;
    logic [ENTRY_W-1:0]   fifo_rdata_s;
    logic                 fifo_empty_s;
    logic [CNT_W-1:0]     fifo_count_next_s;

    mod3_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (in_valid),
        .wdata      ({in_tag, in_data}),
        .pop        (fifo_pop_s),
        .rdata      (fifo_rdata_s),
        .empty      (fifo_empty_s),
        .wr_ready   (in_ready),
        .count_next (fifo_count_next_s)
    );

    // Next-state logic: job launch, core/watchdog completion, result handoff.
    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        run_cnt_d     = run_cnt_q;
        core_x_d      = core_x_q;
        core_e_d      = core_e_q;
        out_valid_d   = out_valid_q;
        out_rem_d     = out_rem_q;
        out_tag_d     = out_tag_q;
        out_steps_d   = out_steps_q;
        out_timeout_d = out_timeout_q;
        fifo_pop_s    = 1'b0;
        case (state_q)
            GAP: begin
                core_e_d = 1'b0;
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            IDLE: begin
                if (!fifo_empty_s) begin
                    core_x_d   = fifo_rdata_s[OPERAND_W-1:0];
                    out_tag_d  = fifo_rdata_s[ENTRY_W-1:OPERAND_W];
                    fifo_pop_s = 1'b1;
                    core_e_d   = 1'b1;
                    run_cnt_d  = '0;
                    state_d    = RUN;
                end else begin
                    core_e_d = 1'b0;
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                // core_f may still be high from the previous job in the first
                // RUN cycle, so it only counts once the counter has moved.
                if (core_f && (run_cnt_q != RUN_W'(0))) begin
                    out_rem_d     = core_s;
                    out_steps_d   = core_i;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                    core_e_d      = 1'b0;
                    state_d       = HOLD;
                end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
                    out_rem_d     = '0;
                    out_steps_d   = core_i;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    core_e_d      = 1'b0;
                    state_d       = HOLD;
                end else begin
                    core_e_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    gap_cnt_d   = '0;
                    state_d     = GAP;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                core_e_d    = 1'b0;
                out_valid_d = 1'b0;
                gap_cnt_d   = '0;
                state_d     = GAP;
            end
        endcase
        busy_d = (fifo_count_next_s != CNT_W'(0)) || (state_d != GAP);
    end

    // State, counters and registered outputs; reset drops core_e immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= GAP;
            gap_cnt_q     <= '0;
            run_cnt_q     <= '0;
            core_x_q      <= '0;
            core_e_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_rem_q     <= '0;
            out_tag_q     <= '0;
            out_steps_q   <= '0;
            out_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            run_cnt_q     <= run_cnt_d;
            core_x_q      <= core_x_d;
            core_e_q      <= core_e_d;
            out_valid_q   <= out_valid_d;
            out_rem_q     <= out_rem_d;
            out_tag_q     <= out_tag_d;
            out_steps_q   <= out_steps_d;
            out_timeout_q <= out_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign core_x      = core_x_q;
    assign core_e      = core_e_q;
    assign out_valid   = out_valid_q;
    assign out_rem     = out_rem_q;
    assign out_tag     = out_tag_q;
    assign out_steps   = out_steps_q;
    assign out_timeout = out_timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mod3_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mod3_operand_sequencer
// Bench with a behavioural mod-3 core stub (latency 3 + x[3:0] cycles, or a
// stuck mode that never finishes), a scoreboard queue filled on accepted
// operands and a monitor that compares every consumed result in order.
// -----------------------------------------------------------------------------
module tb_mod3_operand_sequencer;

    localparam int TAG_W = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 127;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic [3:0]  in_tag = 4'd0;
    logic [63:0] core_x;
    logic        core_e;
    logic [1:0]  core_s = 2'd0;
    logic        core_f = 1'b0;
    logic [6:0]  core_i = 7'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_rem;
    logic [3:0]  out_tag;
    logic [6:0]  out_steps;
    logic        out_timeout;
    logic        busy;

    always #5 clk = ~clk;

    mod3_operand_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .TAG_W      (TAG_W),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_tag      (in_tag),
        .core_x      (core_x),
        .core_e      (core_e),
        .core_s      (core_s),
        .core_f      (core_f),
        .core_i      (core_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rem     (out_rem),
        .out_tag     (out_tag),
        .out_steps   (out_steps),
        .out_timeout (out_timeout),
        .busy        (busy)
    );

    typedef struct {
        logic [1:0] rem;
        logic [3:0] tag;
        logic [6:0] steps;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stuck = 1'b0;
    bit   acc;
    int   last_run = 0;

    // ---------------- behavioural core stub ----------------
    bit          prev_e = 1'b0;
    logic [63:0] x_lat;
    int          run = 0;
    int          lat = 0;
    int          low_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (core_e) begin
            if (!prev_e) begin
                x_lat = core_x;
                run   = 0;
                lat   = 3 + int'(core_x[3:0]);
                checks++;
                if (low_cnt < GAP) begin
                    errors++;
                    $display("FAIL gap_low_cycles got %0d need >= %0d", low_cnt, GAP);
                end
            end else begin
                checks++;
                if (core_x !== x_lat) begin
                    errors++;
                    $display("FAIL core_x_stable got %h want %h", core_x, x_lat);
                end
            end
            run++;
            if (!stuck && run == lat) begin
                core_f = 1'b1;
                core_s = 2'(x_lat % 64'd3);
                core_i = 7'(lat);
            end
        end else begin
            if (prev_e) begin
                last_run = run;
                low_cnt  = 1;
            end else begin
                low_cnt++;
            end
            core_f = 1'b0;
            core_s = 2'd0;
            core_i = 7'd0;
        end
        prev_e = core_e;
    end

    // ---------------- scoreboard: expected on accept ----------------
    exp_t e_in;
    initial forever begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready) begin
            e_in.rem   = stuck ? 2'd0 : 2'(in_data % 64'd3);
            e_in.tag   = in_tag;
            e_in.steps = 7'(3 + int'(in_data[3:0]));
            e_in.tmo   = stuck;
            exp_q.push_back(e_in);
        end
    end

    // ---------------- monitor: compare on consumed result ----------------
    exp_t e_out;
    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got rem=%0d tag=%0d tmo=%0d want none",
                         out_rem, out_tag, out_timeout);
            end else begin
                e_out = exp_q.pop_front();
                if (out_rem !== e_out.rem || out_tag !== e_out.tag ||
                    out_timeout !== e_out.tmo ||
                    (!e_out.tmo && out_steps !== e_out.steps)) begin
                    errors++;
                    $display("FAIL result got rem=%0d tag=%0d tmo=%0d steps=%0d want rem=%0d tag=%0d tmo=%0d steps=%0d",
                             out_rem, out_tag, out_timeout, out_steps,
                             e_out.rem, e_out.tag, e_out.tmo, e_out.steps);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_op(input logic [63:0] x, input logic [3:0] t);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        in_tag   = t;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout op %h not accepted", x);
        end
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    int          accepted;
    bit          seen;
    logic [1:0]  s_rem;
    logic [3:0]  s_tag;
    logic [6:0]  s_steps;
    logic        s_tmo;
    int          sent;

    initial begin
        #2;
        check("reset_outputs",
              {in_ready, core_e, out_valid, busy, out_timeout, out_rem, out_tag, out_steps},
              64'd0);
        check("reset_core_x", core_x, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_first_clk", 64'(in_ready), 64'd1);

        // 1: single operand
        out_ready = 1'b1;
        push_op(64'd117, 4'd0);
        drain(100);

        // 2: back-to-back operands
        push_op(64'd425117, 4'd1);
        push_op(64'd827425117, 4'd2);
        push_op(64'd4294967295, 4'd3);
        push_op(64'hFFFF_FFFF_FFFF_FFFF, 4'd4);
        drain(300);

        // 3: capacity with the result stream blocked
        out_ready = 1'b0;
        accepted  = 0;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            in_data  = 64'd1000 + 64'(j * 7);
            in_tag   = 4'(8 + j);
            seen     = 1'b0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (acc) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (seen) accepted++;
            else break;
        end
        check("capacity_accepted", 64'(accepted), 64'd5);
        check("in_ready_when_full", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(400);
        tick();
        check("in_ready_after_drain", 64'(in_ready), 64'd1);

        // 4: backpressure in HOLD
        out_ready = 1'b0;
        push_op(64'd55, 4'd13);
        push_op(64'd56, 4'd14);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("hold_reached", 64'(seen), 64'd1);
        s_rem = out_rem; s_tag = out_tag; s_steps = out_steps; s_tmo = out_timeout;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_stable",
                  {out_valid, core_e, out_rem, out_tag, out_steps, out_timeout},
                  {1'b1, 1'b0, s_rem, s_tag, s_steps, s_tmo});
        end
        out_ready = 1'b1;
        drain(200);

        // 5: hung core triggers the watchdog, next job is normal
        stuck = 1'b1;
        push_op(64'hDEAD_BEEF_0000_0001, 4'd5);
        drain(400);
        check("watchdog_run_cycles", 64'(last_run), 64'(TMO));
        stuck = 1'b0;
        push_op(64'd1001, 4'd6);
        drain(100);

        // 6: reset in the middle of a job
        push_op(64'h0012_345F, 4'd9);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (core_e) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("run_reached", 64'(seen), 64'd1);
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_outputs", {core_e, out_valid, in_ready}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_empty", {busy, in_ready}, {1'b0, 1'b1});
        push_op(64'd117, 4'd7);
        drain(100);

        // random traffic with random backpressure
        sent = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 4000 && sent < 40; c++) begin
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0:       in_data = {$urandom, $urandom};
                    1:       in_data = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
                    2:       in_data = 64'($urandom_range(0, 20));
                    default: in_data = {32'd0, $urandom};
                endcase
                in_tag = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("random_sent", 64'(sent), 64'd40);
        drain(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
